// File: rtl/wb_forward_pipe_pkg.sv
// -----------------------------------------------------------------------------
// wb_forward_pipe_pkg
//
// Shared definitions for the write-side forwarding pipeline.
//   DW_DEF   : default result / write-data width
//   AW_DEF   : default register address width (32 registers)
//   REG_ZERO : the hardwired-zero register; writes to it are never visible
//   stage_t  : one pipeline stage record {valid, we, wa, load, data} at the
//              default widths (handy for models and debug views)
// -----------------------------------------------------------------------------
package wb_forward_pipe_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [AW_DEF-1:0] wa;
        logic              load;
        logic [DW_DEF-1:0] data;
    } stage_t;

endpackage

// File: rtl/wb_forward_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg
//
// One pipeline stage register. Holds an opaque packed stage record; the
// caller decides its layout. A bubble (or reset) loads an all-zero record,
// which has valid = 0 and therefore never produces a visible write.
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   bubble : load an empty record instead of d on this edge
//   d      : next stage record
//   q      : current stage record
// -----------------------------------------------------------------------------
module wb_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            q_reg <= '0;
        end else begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/wb_forward_pipe.sv
// -----------------------------------------------------------------------------
// wb_forward_pipe
//
// Write-side companion to the register file. Carries each issued
// instruction's destination through the EX, MEM and WB pipeline registers,
// drives the register file's three forwarding ports and its architectural
// write port, and raises a one-cycle stall on a load-use hazard.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   id_valid/id_we/id_wa/id_load: instruction in ID and its destination
//   id_rs/id_rt/id_use_rs/_rt   : ID source registers and whether they are read
//   flush                       : squash the instruction entering EX
//   ex_result                   : ALU result of the instruction in EX
//   me_load_data                : memory read data of the instruction in MEM
//   stall                       : load-use hazard, ID and IF must hold
//   we_ex/wa_ex/wd_ex           : EX forwarding port
//   we_me/wa_me/wd_me           : MEM forwarding port
//   we_wb/wa_wb/wd_wb           : WB forwarding port
//   rf_we/rf_wa/rf_wd           : register file write port
//   retired                     : count of valid instructions leaving WB
// -----------------------------------------------------------------------------
module wb_forward_pipe
    import wb_forward_pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_we,
    input  logic [AW-1:0] id_wa,
    input  logic          id_load,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          flush,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] me_load_data,
    output logic          stall,
    output logic          we_ex,
    output logic [AW-1:0] wa_ex,
    output logic [DW-1:0] wd_ex,
    output logic          we_me,
    output logic [AW-1:0] wa_me,
    output logic [DW-1:0] wd_me,
    output logic          we_wb,
    output logic [AW-1:0] wa_wb,
    output logic [DW-1:0] wd_wb,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [31:0]   retired
);

    // Control part of a stage record. The data part is kept alongside for
    // MEM and WB only: while an instruction sits in EX its value is the live
    // ex_result input, so EX has nothing worth registering.
    typedef struct packed {
        logic          valid;
        logic          we;
        logic          load;
        logic [AW-1:0] wa;
    } ctrl_t;

    localparam int CW   = $bits(ctrl_t);
    localparam int S_EX = 0;
    localparam int S_ME = 1;
    localparam int S_WB = 2;
    localparam int NSTG = 3;

    ctrl_t         ctrl_q [NSTG];
    logic [DW-1:0] data_q [S_ME:S_WB];
    logic [DW-1:0] data_d [S_ME:S_WB];
    logic          wq     [NSTG];

    ctrl_t         ex_d;
    logic          ex_bubble;
    logic          hit_rs;
    logic          hit_rt;
    logic [31:0]   retired_reg;

    // -------------------------------------------------------------------------
    // Stage registers. EX takes the ID instruction (or a bubble); MEM and WB
    // always take the previous stage together with that stage's result.
    // -------------------------------------------------------------------------
    always_comb begin
        ex_d       = '0;
        ex_d.valid = id_valid;
        ex_d.we    = id_we;
        ex_d.load  = id_load;
        ex_d.wa    = id_wa;
    end

    assign data_d[S_ME] = ex_result;
    assign data_d[S_WB] = wd_me;

    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
        if (gi == S_EX) begin : g_ex
            logic [CW-1:0] q;

            wb_stage_reg #(.W(CW)) u_reg (
                .clk    (clk),
                .rst    (rst),
                .bubble (ex_bubble),
                .d      (ex_d),
                .q      (q)
            );

            assign ctrl_q[gi] = q;
        end else begin : g_dat
            logic [CW+DW-1:0] q;

            wb_stage_reg #(.W(CW + DW)) u_reg (
                .clk    (clk),
                .rst    (rst),
                .bubble (1'b0),
                .d      ({ctrl_q[gi-1], data_d[gi]}),
                .q      (q)
            );

            assign {ctrl_q[gi], data_q[gi]} = q;
        end

        // A stage produces a visible write only when it is a real writing
        // instruction whose destination is not the hardwired-zero register.
        assign wq[gi] = ctrl_q[gi].valid & ctrl_q[gi].we
                      & (ctrl_q[gi].wa != AW'(REG_ZERO));
    end

    // -------------------------------------------------------------------------
    // Load-use hazard. A load in EX has no value yet, so a dependent
    // instruction in ID must wait one cycle; by then the load sits in MEM and
    // its memory data is forwarded from there. flush still reports the stall
    // because the stall depends only on what is in EX right now.
    // -------------------------------------------------------------------------
    assign hit_rs    = id_use_rs & (id_rs == ctrl_q[S_EX].wa);
    assign hit_rt    = id_use_rt & (id_rt == ctrl_q[S_EX].wa);
    assign stall     = id_valid & wq[S_EX] & ctrl_q[S_EX].load & (hit_rs | hit_rt);
    assign ex_bubble = flush | stall;

    // -------------------------------------------------------------------------
    // Forwarding ports
    // -------------------------------------------------------------------------
    assign we_ex = wq[S_EX] & ~ctrl_q[S_EX].load;
    assign wa_ex = ctrl_q[S_EX].wa;
    assign wd_ex = ex_result;

    assign we_me = wq[S_ME];
    assign wa_me = ctrl_q[S_ME].wa;
    assign wd_me = ctrl_q[S_ME].load ? me_load_data : data_q[S_ME];

    assign we_wb = wq[S_WB];
    assign wa_wb = ctrl_q[S_WB].wa;
    assign wd_wb = data_q[S_WB];

    // The architectural write is the WB stage itself.
    assign rf_we = we_wb;
    assign rf_wa = wa_wb;
    assign rf_wd = wd_wb;

    // -------------------------------------------------------------------------
    // Retirement counter: every valid instruction leaving WB counts, including
    // non-writing ones and writes to register 0. Wraps naturally.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (ctrl_q[S_WB].valid) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign retired = retired_reg;

endmodule

// File: tb/tb_wb_forward_pipe.sv
module tb_wb_forward_pipe;
    import wb_forward_pipe_pkg::*;

    localparam int DW = DW_DEF;
    localparam int AW = AW_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_we, id_load, id_use_rs, id_use_rt, flush;
    logic [AW-1:0] id_wa, id_rs, id_rt;
    logic [DW-1:0] ex_result, me_load_data;
    logic          stall, we_ex, we_me, we_wb, rf_we;
    logic [AW-1:0] wa_ex, wa_me, wa_wb, rf_wa;
    logic [DW-1:0] wd_ex, wd_me, wd_wb, rf_wd;
    logic [31:0]   retired;

    always #5 clk = ~clk;

    wb_forward_pipe #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_we        (id_we),
        .id_wa        (id_wa),
        .id_load      (id_load),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .flush        (flush),
        .ex_result    (ex_result),
        .me_load_data (me_load_data),
        .stall        (stall),
        .we_ex        (we_ex),
        .wa_ex        (wa_ex),
        .wd_ex        (wd_ex),
        .we_me        (we_me),
        .wa_me        (wa_me),
        .wd_me        (wd_me),
        .we_wb        (we_wb),
        .wa_wb        (wa_wb),
        .wd_wb        (wd_wb),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .retired      (retired)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the instruction record occupying each stage, with the
    // value it will eventually write, plus the retirement count.
    stage_t      m_ex, m_me, m_wb;
    logic [31:0] m_retired;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_writes(input stage_t s);
        return s.valid && s.we && (s.wa != 0);
    endfunction

    function automatic logic m_stall();
        if (!id_valid || !m_writes(m_ex) || !m_ex.load) return 1'b0;
        return (id_use_rs && id_rs == m_ex.wa) || (id_use_rt && id_rt == m_ex.wa);
    endfunction

    task automatic check_model();
        logic          exp_we;
        logic [DW-1:0] exp_wd_me;
        chk("stall", stall, m_stall());
        exp_we = m_writes(m_ex) && !m_ex.load;
        chk("we_ex", we_ex, exp_we);
        if (exp_we) begin
            chk("wa_ex", wa_ex, m_ex.wa);
            chk("wd_ex", wd_ex, ex_result);
        end
        exp_we    = m_writes(m_me);
        exp_wd_me = m_me.load ? me_load_data : m_me.data;
        chk("we_me", we_me, exp_we);
        if (exp_we) begin
            chk("wa_me", wa_me, m_me.wa);
            chk("wd_me", wd_me, exp_wd_me);
        end
        exp_we = m_writes(m_wb);
        chk("we_wb", we_wb, exp_we);
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("wa_wb", wa_wb, m_wb.wa);
            chk("wd_wb", wd_wb, m_wb.data);
            chk("rf_wa", rf_wa, m_wb.wa);
            chk("rf_wd", rf_wd, m_wb.data);
        end
        chk("retired", retired, m_retired);
    endtask

    // Advance the model across one rising edge, then return at the falling edge.
    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (rst) begin
            m_ex = '0; m_me = '0; m_wb = '0; m_retired = '0;
        end else begin
            if (m_wb.valid) m_retired = m_retired + 32'd1;
            m_wb      = m_me;
            m_wb.data = m_me.load ? me_load_data : m_me.data;
            m_me      = m_ex;
            m_me.data = ex_result;
            m_ex      = '0;
            if (!(flush || s)) begin
                m_ex.valid = id_valid;
                m_ex.we    = id_we;
                m_ex.wa    = id_wa;
                m_ex.load  = id_load;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        if (!rst) check_model();
        tick();
    endtask

    task automatic idle();
        id_valid = 0; id_we = 0; id_wa = '0; id_load = 0;
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; flush = 0;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] wa, input logic ld,
                         input logic [AW-1:0] rs, input logic urs,
                         input logic [AW-1:0] rt, input logic urt);
        id_valid = 1; id_we = we; id_wa = wa; id_load = ld;
        id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt; flush = 0;
    endtask

    task automatic drain();
        idle();
        repeat (4) begin #1; step(); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic        hold;
        m_ex = '0; m_me = '0; m_wb = '0; m_retired = '0;
        ex_result = '0; me_load_data = '0;

        // ---- Reset with a valid writing instruction presented throughout ----
        rst = 1; idle();
        issue(1, 5'd9, 0, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        tick(); tick();
        rst = 0; idle(); #1;
        chk("rst_we_ex", we_ex, 0);
        chk("rst_we_me", we_me, 0);
        chk("rst_we_wb", we_wb, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_stall", stall, 0);
        chk("rst_retired", retired, 0);
        step();

        // ---- ALU chain: r3 <= 0x11, r4 <= 0x22 back to back ----
        issue(1, 5'd3, 0, 5'd0, 0, 5'd0, 0); ex_result = 32'h0; #1; step();
        issue(1, 5'd4, 0, 5'd0, 0, 5'd0, 0); ex_result = 32'h11; #1;
        chk("alu_ex_we", we_ex, 1); chk("alu_ex_wa", wa_ex, 3); chk("alu_ex_wd", wd_ex, 32'h11);
        step();
        idle(); ex_result = 32'h22; #1;
        chk("alu_me_we", we_me, 1); chk("alu_me_wa", wa_me, 3); chk("alu_me_wd", wd_me, 32'h11);
        chk("alu_ex2_wa", wa_ex, 4);
        step();
        ex_result = 32'h0; #1;
        chk("alu_rf_we", rf_we, 1); chk("alu_rf_wa", rf_wa, 3); chk("alu_rf_wd", rf_wd, 32'h11);
        step();
        #1;
        chk("alu_rf2_wa", rf_wa, 4); chk("alu_rf2_wd", rf_wd, 32'h22);
        step();
        drain();

        // ---- Load-use: load r5, then a reader of r5 that writes r6 ----
        issue(1, 5'd5, 1, 5'd0, 0, 5'd0, 0); #1; step();
        issue(1, 5'd6, 0, 5'd5, 1, 5'd0, 0); ex_result = 32'h66; #1;
        chk("lu_stall", stall, 1); chk("lu_load_not_fwd", we_ex, 0);
        step();
        me_load_data = 32'hDEADBEEF; #1;
        chk("lu_stall_once", stall, 0); chk("lu_bubble", we_ex, 0);
        chk("lu_me_we", we_me, 1); chk("lu_me_wa", wa_me, 5); chk("lu_me_wd", wd_me, 32'hDEADBEEF);
        step();
        idle(); me_load_data = 32'h0; #1;
        chk("lu_ex_wa", wa_ex, 6); chk("lu_rf_we", rf_we, 1);
        chk("lu_rf_wa", rf_wa, 5); chk("lu_rf_wd", rf_wd, 32'hDEADBEEF);
        step();
        drain();

        // ---- Write to register 0 ----
        base = m_retired;
        issue(1, 5'd0, 0, 5'd0, 0, 5'd0, 0); ex_result = 32'h55; #1; step();
        idle(); #1; chk("r0_we_ex", we_ex, 0); step();
        #1; chk("r0_we_me", we_me, 0); step();
        #1; chk("r0_we_wb", we_wb, 0); chk("r0_rf_we", rf_we, 0); chk("r0_ret_pre", retired, base); step();
        #1; chk("r0_ret_post", retired, base + 32'd1); step();
        drain();

        // ---- Flush together with a load-use stall ----
        issue(1, 5'd7, 1, 5'd0, 0, 5'd0, 0); #1; step();
        issue(1, 5'd8, 0, 5'd0, 0, 5'd7, 1); flush = 1; #1;
        chk("fl_stall", stall, 1);
        step();
        idle(); #1;
        chk("fl_bubble", we_ex, 0); chk("fl_load_me_wa", wa_me, 7);
        step();
        #1; chk("fl_no_me", we_me, 0); step();
        #1; chk("fl_no_wb", we_wb, 0); step();
        drain();

        // ---- Retirement counter wrap ----
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        m_retired = 32'hFFFF_FFFF;
        issue(1, 5'd1, 0, 5'd0, 0, 5'd0, 0); #1; step();
        idle(); #1; step();
        #1; step();
        #1; chk("wrap_pre", retired, 32'hFFFF_FFFF); step();
        #1; chk("wrap_zero", retired, 32'h0); step();

        // ---- Randomized traffic with one mid-run reset ----
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                id_valid  = ($urandom_range(0, 9) < 8);
                id_we     = ($urandom_range(0, 3) != 0);
                id_wa     = AW'($urandom_range(0, 7));
                id_load   = ($urandom_range(0, 2) == 0);
                id_rs     = AW'($urandom_range(0, 7));
                id_rt     = AW'($urandom_range(0, 7));
                id_use_rs = 1'($urandom_range(0, 1));
                id_use_rt = 1'($urandom_range(0, 1));
            end
            flush        = ($urandom_range(0, 9) == 0);
            ex_result    = $urandom();
            me_load_data = $urandom();
            rst          = (n == 200);
            #1;
            hold = m_stall() && !rst;
            step();
        end
        rst = 0;
        idle(); #1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
